// File: rtl/mac6_accumulator.sv
`timescale 1ns/1ps
// mac6_accumulator
// Sequential multiply-accumulate wrapper around a 6x6 carry-save array
// multiplier. Operand pairs arrive over a valid/ready handshake, are
// registered into the multiplier, and each 12-bit product is added into a
// saturating accumulator. After N_TERMS pairs the sum is offered on a second
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   source presents an operand pair (a, b)
//   in_ready   block can accept a pair (IDLE or ACCUM)
//   a, b       unsigned 6-bit operands
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   acc_out    accumulator, meaningful while out_valid=1
//   ovf        sticky saturation flag for the current accumulation
//   term_cnt   pairs accepted in the current accumulation
//
// Also contains multiply6x6, the purely combinational multiplier.

module multiply6x6 (
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic [11:0] p
);
  logic [11:0] s;
  logic [11:0] c;
  logic [11:0] pp;
  logic [11:0] ns;
  logic [11:0] nc;

  // Linear carry-save array: each partial-product row is folded into the
  // sum/carry pair by a row of full adders; one carry-propagate add at the end.
  always_comb begin
    s  = {6'd0, a & {6{b[0]}}};
    c  = '0;
    pp = '0;
    ns = '0;
    nc = '0;
    for (int i = 1; i < 6; i++) begin
      pp = 12'(a & {6{b[i]}}) << i;
      ns = s ^ c ^ pp;
      nc = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = ns;
      c  = nc;
    end
    p = s + c;
  end
endmodule

module mac6_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       a,
  input  logic [5:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [3:0]       term_cnt
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NT = 4'(N_TERMS);

  state_t           state;
  logic             accept;
  logic [5:0]       a_p1;
  logic [5:0]       b_p1;
  logic             vld_p1;
  logic [11:0]      prod_p1;
  logic [ACC_W-1:0] acc_p2;
  logic [ACC_W:0]   sat_p2;

  // Returns {overflow, value}; the sum cannot exceed ACC_W+1 bits because the
  // product is at most 3969.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc_v,
                                             input logic [11:0]      p_v);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc_v} + {{(ACC_W - 11){1'b0}}, p_v};
    if (sum[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return {1'b0, sum[ACC_W-1:0]};
  endfunction

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign acc_out   = acc_p2;

  multiply6x6 u_mul (
    .a (a_p1),
    .b (b_p1),
    .p (prod_p1)
  );

  assign sat_p2 = sat_add(acc_p2, prod_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_p1     <= '0;
      b_p1     <= '0;
      vld_p1   <= 1'b0;
      term_cnt <= '0;
      acc_p2   <= '0;
      ovf      <= 1'b0;
    end else begin
      // Stage 1: operand register
      vld_p1 <= accept;
      if (accept) begin
        a_p1     <= a;
        b_p1     <= b;
        term_cnt <= term_cnt + 4'd1;
      end

      // Stage 2: saturating accumulate
      if (vld_p1) begin
        acc_p2 <= sat_p2[ACC_W-1:0];
        if (sat_p2[ACC_W]) ovf <= 1'b1;
      end

      case (state)
        IDLE:    if (accept) state <= (NT == 4'd1) ? DRAIN : ACCUM;
        ACCUM:   if (accept && (term_cnt + 4'd1 == NT)) state <= DRAIN;
        DRAIN:   state <= DONE;
        DONE: begin
          if (out_ready) begin
            state    <= IDLE;
            acc_p2   <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac6_accumulator.sv
`timescale 1ns/1ps
module tb_mac6_accumulator;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: N_TERMS=4, ACC_W=16
  logic        rst_n0, in_valid0, in_ready0, out_valid0, out_ready0, ovf0;
  logic [5:0]  a0, b0;
  logic [15:0] acc_out0;
  logic [3:0]  term_cnt0;
  // DUT1: N_TERMS=2, ACC_W=12
  logic        rst_n1, in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
  logic [5:0]  a1, b1;
  logic [11:0] acc_out1;
  logic [3:0]  term_cnt1;

  mac6_accumulator #(.N_TERMS(4), .ACC_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .acc_out(acc_out0), .ovf(ovf0), .term_cnt(term_cnt0));

  mac6_accumulator #(.N_TERMS(2), .ACC_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .acc_out(acc_out1), .ovf(ovf1), .term_cnt(term_cnt1));

  typedef struct packed {
    logic [15:0] acc;
    logic        ovf;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) check("dut0_unexpected_result", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_acc", 32'(acc_out0), 32'(e.acc));
        check("dut0_ovf", 32'(ovf0), 32'(e.ovf));
        check("dut0_cnt", 32'(term_cnt0), 32'(e.cnt));
      end
    end
    if (out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("dut1_unexpected_result", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_acc", 32'(acc_out1), 32'(e.acc));
        check("dut1_ovf", 32'(ovf1), 32'(e.ovf));
        check("dut1_cnt", 32'(term_cnt1), 32'(e.cnt));
      end
    end
  end

  // Present a pair and hold it until accepted; returns at posedge+1.
  task automatic send(input int d, input logic [5:0] av, input logic [5:0] bv);
    bit done = 1'b0;
    bit rdy;
    if (d == 0) begin in_valid0 = 1'b1; a0 = av; b0 = bv; end
    else        begin in_valid1 = 1'b1; a1 = av; b1 = bv; end
    for (int k = 0; k < 50 && !done; k++) begin
      rdy = (d == 0) ? in_ready0 : in_ready1;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    if (!done) check("accept_timeout", 0, 1);
    if (d == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
  endtask

  task automatic wait_out(input int d);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if ((d == 0) ? out_valid0 : out_valid1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) check("out_valid_timeout", 0, 1);
  endtask

  task automatic push0(input int acc, input bit o, input int cnt);
    exp_t e;
    e.acc = 16'(acc); e.ovf = o; e.cnt = 4'(cnt);
    q0.push_back(e);
  endtask

  task automatic push1(input int acc, input bit o, input int cnt);
    exp_t e;
    e.acc = 16'(acc); e.ovf = o; e.cnt = 4'(cnt);
    q1.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;

    // Reset values before any clock edge
    #2;
    check("rst_in_ready",  32'(in_ready0), 1);
    check("rst_out_valid", 32'(out_valid0), 0);
    check("rst_acc",       32'(acc_out0), 0);
    check("rst_ovf",       32'(ovf0), 0);
    check("rst_cnt",       32'(term_cnt0), 0);
    check("rst1_in_ready", 32'(in_ready1), 1);
    #10;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;

    // Back-to-back, exact latency
    push0(769, 1'b0, 4);
    send(0, 6'd5, 6'd3);
    send(0, 6'd9, 6'd6);
    send(0, 6'd15, 6'd15);
    send(0, 6'd25, 6'd19);
    check("b2b_drain_out_valid", 32'(out_valid0), 0);
    check("b2b_drain_in_ready",  32'(in_ready0), 0);
    @(posedge clk); #1;
    check("b2b_out_valid", 32'(out_valid0), 1);
    check("b2b_acc",       32'(acc_out0), 769);
    check("b2b_cnt",       32'(term_cnt0), 4);
    @(posedge clk); #1;
    check("b2b_idle_out_valid", 32'(out_valid0), 0);
    check("b2b_idle_in_ready",  32'(in_ready0), 1);
    check("b2b_idle_acc",       32'(acc_out0), 0);

    // Max operands
    push0(15876, 1'b0, 4);
    for (int i = 0; i < 4; i++) send(0, 6'd63, 6'd63);
    wait_out(0);
    check("max_acc", 32'(acc_out0), 15876);
    check("max_ovf", 32'(ovf0), 0);
    @(posedge clk); #1;

    // Gaps and backpressure
    out_ready0 = 1'b0;
    push0(769, 1'b0, 4);
    send(0, 6'd5, 6'd3);   repeat (3) begin @(posedge clk); #1; end
    send(0, 6'd9, 6'd6);   repeat (3) begin @(posedge clk); #1; end
    send(0, 6'd15, 6'd15); repeat (3) begin @(posedge clk); #1; end
    send(0, 6'd25, 6'd19);
    wait_out(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid0), 1);
      check("bp_acc",       32'(acc_out0), 769);
      check("bp_in_ready",  32'(in_ready0), 0);
    end
    @(posedge clk); #1;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_out_valid", 32'(out_valid0), 0);
    check("bp_hs_acc",       32'(acc_out0), 0);
    check("bp_hs_in_ready",  32'(in_ready0), 1);
    check("bp_hs_cnt",       32'(term_cnt0), 0);

    // Saturation on the ACC_W=12, N_TERMS=2 instance
    push1(4095, 1'b1, 2);
    send(1, 6'd63, 6'd63);
    send(1, 6'd63, 6'd63);
    wait_out(1);
    check("sat_acc", 32'(acc_out1), 4095);
    check("sat_ovf", 32'(ovf1), 1);
    @(posedge clk); #1;
    check("sat_ovf_cleared", 32'(ovf1), 0);
    push1(5, 1'b0, 2);
    send(1, 6'd1, 6'd1);
    send(1, 6'd2, 6'd2);
    wait_out(1);
    check("post_sat_acc", 32'(acc_out1), 5);
    check("post_sat_ovf", 32'(ovf1), 0);
    @(posedge clk); #1;

    // Reset mid-accumulation
    send(0, 6'd5, 6'd3);
    send(0, 6'd9, 6'd6);
    #2;
    rst_n0 = 1'b0;
    #0.5;
    check("mid_rst_in_ready",  32'(in_ready0), 1);
    check("mid_rst_out_valid", 32'(out_valid0), 0);
    check("mid_rst_acc",       32'(acc_out0), 0);
    check("mid_rst_cnt",       32'(term_cnt0), 0);
    check("mid_rst_ovf",       32'(ovf0), 0);
    #0.5;
    rst_n0 = 1'b1;
    @(posedge clk); #1;
    push0(8, 1'b0, 4);
    for (int i = 0; i < 4; i++) send(0, 6'd1, 6'd2);
    wait_out(0);
    check("after_rst_acc", 32'(acc_out0), 8);
    @(posedge clk); #1;

    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
